// File: rtl/pipe_hazard_if.sv
// Hazard-unit signal bundle between the pipeline datapath and pipe_hazard_unit.
//   master : pipeline side. Drives the register addresses and control bits,
//            and consumes the hold/clear/forward controls.
//   slave  : hazard unit side.
// Pipeline status (inputs to the unit):
//   id_ra1/id_ra2, id_use1/id_use2              ID source registers and read enables
//   ex_ra3, ex_regwrite, ex_memread             EX destination and controls
//   mem_ra3, mem_regwrite, mem_memread,
//   mem_memwrite, mem_ready                     MEM destination, controls, memory done
//   ex_branch_taken                             taken branch/jump resolved in EX
// Pipeline controls (outputs of the unit):
//   stall_pc, stall_if_id, bubble_id_ex         load-use stall
//   flush_if_id, flush_id_ex                    wrong-path clear
//   freeze                                      hold every segment and the PC
//   fwd_a, fwd_b                                EX operand selects (registered)
//   err_timeout                                 sticky memory-timeout flag
//   stall_cnt, flush_cnt                        saturating performance counters
interface pipe_hazard_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  id_ra1;
  logic [RA_W-1:0]  id_ra2;
  logic             id_use1;
  logic             id_use2;
  logic [RA_W-1:0]  ex_ra3;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [RA_W-1:0]  mem_ra3;
  logic             mem_regwrite;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             mem_ready;
  logic             ex_branch_taken;

  logic             stall_pc;
  logic             stall_if_id;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ra1, id_ra2, id_use1, id_use2, ex_ra3, ex_regwrite, ex_memread,
           mem_ra3, mem_regwrite, mem_memread, mem_memwrite, mem_ready,
           ex_branch_taken,
    input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
           freeze, fwd_a, fwd_b, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ra1, id_ra2, id_use1, id_use2, ex_ra3, ex_regwrite, ex_memread,
           mem_ra3, mem_regwrite, mem_memread, mem_memwrite, mem_ready,
           ex_branch_taken,
    output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
           freeze, fwd_a, fwd_b, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// It inserts a one-cycle load-use bubble, freezes the whole pipeline while
// the data memory is not ready (with a timeout release), squashes wrong-path
// instructions after a taken branch, selects the EX operand forwarding
// sources, and counts stall and flush events.
// Ports:
//   clk  pipeline clock
//   rst  synchronous, active-high reset
//   hz   pipe_hazard_if.slave bundle (pipeline status in, controls out)
// Priority inside a cycle: memory freeze > taken branch > load-use.
module pipe_hazard_unit #(
  parameter int RA_W         = 4,
  parameter int FLUSH_DEPTH  = 2,
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 16,
  parameter bit R0_ZERO      = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;

  state_t           state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [1:0]       flush_left, flush_left_nx;

  logic stall, flush_if, flush_ex, freeze, set_err;
  logic [1:0]       fwd_a, fwd_b;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && !(R0_ZERO && (a == '0));
  endfunction

  // EX result (non-load) beats the older MEM result.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] ra,
    input logic            ex_rw,
    input logic            ex_mr,
    input logic [RA_W-1:0] ex_rd,
    input logic            mem_rw,
    input logic [RA_W-1:0] mem_rd
  );
    if (ex_rw && !ex_mr && match(ex_rd, ra)) return 2'b01;
    if (mem_rw && match(mem_rd, ra))         return 2'b10;
    return 2'b00;
  endfunction

  logic lu, mreq, mem_busy, mem_hold, timeout;

  assign lu = hz.ex_memread && hz.ex_regwrite &&
              ((hz.id_use1 && match(hz.ex_ra3, hz.id_ra1)) ||
               (hz.id_use2 && match(hz.ex_ra3, hz.id_ra2)));
  assign mreq = hz.mem_memread || hz.mem_memwrite;

  // Once waiting, the access is frozen in MEM, so only ready matters.
  assign mem_busy = (state == MEM_WAIT) ? !hz.mem_ready : (mreq && !hz.mem_ready);
  assign mem_hold = mem_busy && (wait_cnt != WAIT_W'(MEM_WAIT_MAX));
  assign timeout  = mem_busy && (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nx      = state;
    wait_cnt_nx   = '0;
    flush_left_nx = flush_left;
    stall         = 1'b0;
    flush_if      = 1'b0;
    flush_ex      = 1'b0;
    freeze        = 1'b0;
    set_err       = 1'b0;
    if (!rst) begin
      case (state)
        FLUSH: begin
          // Wrong-path slots: branch and load-use are ignored here.
          if (mem_hold) begin
            freeze      = 1'b1;
            wait_cnt_nx = wait_cnt + WAIT_W'(1);
          end else begin
            set_err       = timeout;
            flush_if      = 1'b1;
            flush_left_nx = flush_left - 2'd1;
            if (flush_left == 2'd1) state_nx = RUN;
          end
        end
        default: begin // RUN, LOAD_STALL, MEM_WAIT
          if (mem_hold) begin
            freeze      = 1'b1;
            wait_cnt_nx = wait_cnt + WAIT_W'(1);
            state_nx    = MEM_WAIT;
          end else begin
            set_err  = timeout;
            state_nx = RUN;
            if (hz.ex_branch_taken) begin
              flush_if = 1'b1;
              flush_ex = 1'b1;
              if (FLUSH_DEPTH > 1) begin
                state_nx      = FLUSH;
                flush_left_nx = 2'(FLUSH_DEPTH - 1);
              end
            end else if (lu && state != LOAD_STALL) begin
              // The load has moved on to MEM after one bubble; WB forwarding covers it.
              stall    = 1'b1;
              state_nx = LOAD_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      flush_left  <= '0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_cnt_nx;
      flush_left <= flush_left_nx;
      if (set_err) err_timeout <= 1'b1;
      if (!freeze) begin
        if (stall || flush_ex) begin
          fwd_a <= 2'b00;
          fwd_b <= 2'b00;
        end else begin
          fwd_a <= fwd_sel(hz.id_ra1, hz.ex_regwrite, hz.ex_memread, hz.ex_ra3,
                           hz.mem_regwrite, hz.mem_ra3);
          fwd_b <= fwd_sel(hz.id_ra2, hz.ex_regwrite, hz.ex_memread, hz.ex_ra3,
                           hz.mem_regwrite, hz.mem_ra3);
        end
      end
      if ((stall || freeze) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ex && flush_cnt != '1)          flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_pc     = stall;
  assign hz.stall_if_id  = stall;
  assign hz.bubble_id_ex = stall;
  assign hz.flush_if_id  = flush_if;
  assign hz.flush_id_ex  = flush_ex;
  assign hz.freeze       = freeze;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.err_timeout  = err_timeout;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed vector table, hand-built
// saturation/reset sequence, then randomized traffic against a reference model.
module tb_pipe_hazard_unit;

  localparam int RA_W         = 4;
  localparam int FLUSH_DEPTH  = 2;
  localparam int MEM_WAIT_MAX = 8;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  pipe_hazard_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();

  pipe_hazard_unit #(
    .RA_W(RA_W), .FLUSH_DEPTH(FLUSH_DEPTH), .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W(CNT_W), .R0_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RA_W-1:0] id_ra1, id_ra2;
    logic            id_use1, id_use2;
    logic [RA_W-1:0] ex_ra3;
    logic            ex_regwrite, ex_memread;
    logic [RA_W-1:0] mem_ra3;
    logic            mem_regwrite, mem_memread, mem_memwrite, mem_ready;
    logic            ex_branch_taken;
  } in_t;

  // ctl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze}
  typedef struct {
    in_t        i;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_wait;        // consecutive frozen cycles of the current memory access
  bit         m_in_wait;     // a memory access is already being waited on
  int         m_flush_left;  // wrong-path fetch slots still to clear
  bit         m_after_load;  // a load-use bubble was issued last cycle
  bit         m_err;
  logic [1:0] m_fa, m_fb;
  int         m_stall, m_flush;
  bit         e_stall, e_flush_if, e_flush_ex, e_freeze, e_timeout;

  function automatic bit same(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && (a != 0);
  endfunction

  function automatic logic [1:0] fwd_of(input in_t i, input logic [RA_W-1:0] ra);
    if (i.ex_regwrite && !i.ex_memread && same(i.ex_ra3, ra)) return 2'b01;
    if (i.mem_regwrite && same(i.mem_ra3, ra)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_in_wait = 0; m_flush_left = 0; m_after_load = 0; m_err = 0;
    m_fa = 2'b00; m_fb = 2'b00; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval(input in_t i, input logic r);
    bit busy, lu;
    e_stall = 0; e_flush_if = 0; e_flush_ex = 0; e_freeze = 0; e_timeout = 0;
    if (r) return;
    busy = m_in_wait ? !i.mem_ready
                     : ((i.mem_memread || i.mem_memwrite) && !i.mem_ready);
    lu = i.ex_memread && i.ex_regwrite &&
         ((i.id_use1 && same(i.ex_ra3, i.id_ra1)) || (i.id_use2 && same(i.ex_ra3, i.id_ra2)));
    if (busy && m_wait < MEM_WAIT_MAX) e_freeze = 1;
    else begin
      e_timeout = busy;
      if (m_flush_left > 0) e_flush_if = 1;
      else if (i.ex_branch_taken) begin e_flush_if = 1; e_flush_ex = 1; end
      else if (lu && !m_after_load) e_stall = 1;
    end
  endtask

  task automatic model_step(input in_t i, input logic r);
    if (r) begin model_reset(); return; end
    if (e_freeze) begin m_wait++; m_in_wait = (m_flush_left == 0); end
    else begin m_wait = 0; m_in_wait = 0; end
    if (e_timeout) m_err = 1;
    if (!e_freeze) begin
      if (m_flush_left > 0) m_flush_left--;
      else if (e_flush_ex) m_flush_left = FLUSH_DEPTH - 1;
      if (e_stall || e_flush_ex) begin m_fa = 2'b00; m_fb = 2'b00; end
      else begin m_fa = fwd_of(i, i.id_ra1); m_fb = fwd_of(i, i.id_ra2); end
    end
    m_after_load = e_stall;
    if ((e_stall || e_freeze) && m_stall < CNT_MAX) m_stall++;
    if (e_flush_ex && m_flush < CNT_MAX) m_flush++;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic in_t idle();
    in_t t;
    t.id_ra1 = '0; t.id_ra2 = '0; t.id_use1 = 0; t.id_use2 = 0;
    t.ex_ra3 = '0; t.ex_regwrite = 0; t.ex_memread = 0;
    t.mem_ra3 = '0; t.mem_regwrite = 0; t.mem_memread = 0; t.mem_memwrite = 0;
    t.mem_ready = 1; t.ex_branch_taken = 0;
    return t;
  endfunction

  function automatic in_t rand_in();
    in_t t;
    t.id_ra1 = RA_W'($urandom_range(0, 3)); t.id_ra2 = RA_W'($urandom_range(0, 3));
    t.id_use1 = ($urandom_range(0, 9) < 7); t.id_use2 = ($urandom_range(0, 9) < 7);
    t.ex_ra3 = RA_W'($urandom_range(0, 3));
    t.ex_regwrite = ($urandom_range(0, 9) < 6); t.ex_memread = ($urandom_range(0, 9) < 3);
    t.mem_ra3 = RA_W'($urandom_range(0, 3));
    t.mem_regwrite = ($urandom_range(0, 9) < 6);
    t.mem_memread = ($urandom_range(0, 9) < 2); t.mem_memwrite = ($urandom_range(0, 9) < 1);
    t.mem_ready = ($urandom_range(0, 9) < 7);
    t.ex_branch_taken = ($urandom_range(0, 99) < 15);
    return t;
  endfunction

  task automatic drive(input in_t t);
    hz.id_ra1 = t.id_ra1; hz.id_ra2 = t.id_ra2; hz.id_use1 = t.id_use1; hz.id_use2 = t.id_use2;
    hz.ex_ra3 = t.ex_ra3; hz.ex_regwrite = t.ex_regwrite; hz.ex_memread = t.ex_memread;
    hz.mem_ra3 = t.mem_ra3; hz.mem_regwrite = t.mem_regwrite;
    hz.mem_memread = t.mem_memread; hz.mem_memwrite = t.mem_memwrite;
    hz.mem_ready = t.mem_ready; hz.ex_branch_taken = t.ex_branch_taken;
  endtask

  // One clock: drive, check controls mid-cycle, clock, check registered outputs.
  task automatic run_cycle(input in_t t, input logic r,
                           output logic [5:0] got_ctl, output logic [1:0] got_fa,
                           output logic [1:0] got_fb);
    drive(t);
    rst = r;
    #2;
    model_eval(t, r);
    got_ctl = {hz.stall_pc, hz.stall_if_id, hz.bubble_id_ex, hz.flush_if_id, hz.flush_id_ex, hz.freeze};
    check("ctl", 32'(got_ctl),
          32'({e_stall, e_stall, e_stall, e_flush_if, e_flush_ex, e_freeze}));
    @(posedge clk);
    #1;
    model_step(t, r);
    got_fa = hz.fwd_a;
    got_fb = hz.fwd_b;
    check("fwd_a", 32'(got_fa), 32'(m_fa));
    check("fwd_b", 32'(got_fb), 32'(m_fb));
    check("err_timeout", 32'(hz.err_timeout), 32'(m_err));
    check("stall_cnt", 32'(hz.stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
  endtask

  vec_t tbl[$];

  function automatic void add(input in_t t, input logic [5:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.i = t; v.ctl = ctl; v.fa = fa; v.fb = fb;
    tbl.push_back(v);
  endfunction

  initial begin
    in_t        t, lu_t;
    logic [5:0] g_ctl;
    logic [1:0] g_fa, g_fb;

    model_reset();
    rst = 1'b1;
    drive(idle());
    run_cycle(idle(), 1'b1, g_ctl, g_fa, g_fb);
    run_cycle(idle(), 1'b1, g_ctl, g_fa, g_fb);
    check("reset_outputs",
          32'({hz.stall_pc, hz.stall_if_id, hz.bubble_id_ex, hz.flush_if_id, hz.flush_id_ex,
               hz.freeze, hz.fwd_a, hz.fwd_b, hz.err_timeout}), 32'd0);
    check("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // ---------- directed table ----------
    lu_t = idle();
    lu_t.ex_memread = 1; lu_t.ex_regwrite = 1; lu_t.ex_ra3 = 5; lu_t.id_ra1 = 5; lu_t.id_use1 = 1;
    // load-use: one bubble, then the load sits in MEM and is forwarded from WB
    add(lu_t, 6'b111000, 2'b00, 2'b00);
    t = lu_t; t.mem_ra3 = 5; t.mem_regwrite = 1; t.mem_memread = 1;
    add(t, 6'b000000, 2'b10, 2'b00);
    add(idle(), 6'b000000, 2'b00, 2'b00);
    // EX result beats MEM; destination r0 never forwards
    t = idle(); t.ex_regwrite = 1; t.ex_ra3 = 3; t.id_ra2 = 3; t.mem_ra3 = 3; t.mem_regwrite = 1;
    add(t, 6'b000000, 2'b00, 2'b01);
    t.ex_ra3 = 0;
    add(t, 6'b000000, 2'b00, 2'b10);
    // memory wait: three frozen cycles hold the forwarding selects
    t = idle(); t.mem_memread = 1; t.mem_ready = 0; t.ex_regwrite = 1; t.ex_ra3 = 3; t.id_ra1 = 3;
    for (int k = 0; k < 3; k++) add(t, 6'b000001, 2'b00, 2'b10);
    t.mem_ready = 1;
    add(t, 6'b000000, 2'b01, 2'b00);
    add(idle(), 6'b000000, 2'b00, 2'b00);
    // taken branch together with load-use, second branch during FLUSH ignored
    t = lu_t; t.ex_branch_taken = 1;
    add(t, 6'b000110, 2'b00, 2'b00);
    add(t, 6'b000100, 2'b00, 2'b00);
    add(idle(), 6'b000000, 2'b00, 2'b00);
    // timeout: eight frozen cycles then released with no ready
    t = idle(); t.mem_memwrite = 1; t.mem_ready = 0;
    for (int k = 0; k < MEM_WAIT_MAX; k++) add(t, 6'b000001, 2'b00, 2'b00);
    add(t, 6'b000000, 2'b00, 2'b00);
    add(idle(), 6'b000000, 2'b00, 2'b00);

    for (int k = 0; k < tbl.size(); k++) begin
      run_cycle(tbl[k].i, 1'b0, g_ctl, g_fa, g_fb);
      check($sformatf("tbl%0d_ctl", k), 32'(g_ctl), 32'(tbl[k].ctl));
      check($sformatf("tbl%0d_fwd_a", k), 32'(g_fa), 32'(tbl[k].fa));
      check($sformatf("tbl%0d_fwd_b", k), 32'(g_fb), 32'(tbl[k].fb));
    end
    check("tbl_stall_cnt", 32'(hz.stall_cnt), 32'd12);
    check("tbl_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    check("tbl_err_sticky", 32'(hz.err_timeout), 32'd1);

    // ---------- saturation, then reset in the middle of a memory wait ----------
    run_cycle(idle(), 1'b1, g_ctl, g_fa, g_fb);
    t = idle(); t.mem_memread = 1; t.mem_ready = 0;
    for (int k = 0; k < 24; k++) run_cycle(t, 1'b0, g_ctl, g_fa, g_fb);
    check("sat_stall_cnt", 32'(hz.stall_cnt), 32'(CNT_MAX));
    check("sat_freeze_active", 32'(hz.freeze), 32'd1);
    run_cycle(t, 1'b1, g_ctl, g_fa, g_fb);
    run_cycle(idle(), 1'b0, g_ctl, g_fa, g_fb);
    check("rst_wait_ctl", 32'(g_ctl), 32'd0);
    check("rst_wait_cnt", 32'(hz.stall_cnt), 32'd0);
    check("rst_wait_err", 32'(hz.err_timeout), 32'd0);

    // ---------- randomized traffic against the model ----------
    for (int k = 0; k < 3000; k++)
      run_cycle(rand_in(), ($urandom_range(0, 199) == 0), g_ctl, g_fa, g_fb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Replaces the free-running pipeline with controlled stalls for:
  - load-use hazards,
  - multi-cycle data memory (ready handshake with timeout),
  - taken-branch squash, over a parametrised number of cycles.
- Produces registered forwarding selects for the EX operands and saturating stall/flush performance counters.
- Sits beside the pipeline segment registers and drives their hold/clear inputs.

Parameters:
RA_W, 4, register address width
FLUSH_DEPTH, 2, cycles flush_if_id is held after a taken branch (1..4; covers synchronous instruction ROM latency)
MEM_WAIT_MAX, 8, max consecutive not-ready cycles before timeout release
CNT_W, 16, width of performance counters
R0_ZERO, 1, 1 = register 0 never matches a hazard/forward compare

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_ra1, id_ra2  in  RA_W  source registers of the instruction in ID
id_use1, id_use2  in  1  the corresponding source is actually read
ex_ra3  in  RA_W  destination register in EX
ex_regwrite, ex_memread  in  1  EX control bits
mem_ra3  in  RA_W  destination register in MEM
mem_regwrite, mem_memread, mem_memwrite  in  1  MEM control bits
mem_ready  in  1  data memory done this cycle
ex_branch_taken  in  1  jump unit result in EX
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
bubble_id_ex  out  1  load NOP controls into ID/EX
flush_if_id, flush_id_ex  out  1  clear segment
freeze  out  1  hold all segment registers and PC
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM alu_out, 10 WB data (registered)
err_timeout  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (synchronous, active-high, clk): FSM to RUN; all outputs 0; counters 0; err_timeout 0; wait counter 0.
- Match rules:
  - match(a,b) = (a==b) && !(R0_ZERO && a==0).
  - lu = ex_memread & ex_regwrite & ((id_use1 & match(ex_ra3,id_ra1)) | (id_use2 & match(ex_ra3,id_ra2))).
  - mreq = mem_memread | mem_memwrite.
- Priority per cycle: freeze > branch > load-use.
- States:
  - RUN:
    - mreq & !mem_ready: freeze=1 combinationally this cycle, go MEM_WAIT with wait counter=1.
    - Else if ex_branch_taken: flush_if_id=flush_id_ex=1; flush_cnt+1; go FLUSH if FLUSH_DEPTH>1, else stay RUN.
    - Else if lu: stall_pc=stall_if_id=bubble_id_ex=1; go LOAD_STALL.
  - LOAD_STALL: no stall outputs; lu is not re-evaluated (load is now in MEM); freeze and branch rules apply as in RUN; return to RUN. The load-use bubble is exactly one cycle.
  - MEM_WAIT:
    - freeze=1 while !mem_ready; the wait counter increments each cycle.
    - mem_ready=1: freeze=0 that cycle, return to RUN. A branch in EX held during the freeze is evaluated in that same cycle with RUN rules.
    - Counter reaches MEM_WAIT_MAX with no ready: set err_timeout, freeze=0, return to RUN.
  - FLUSH:
    - flush_if_id=1 for FLUSH_DEPTH-1 further cycles, then RUN.
    - ex_branch_taken and lu are ignored (wrong-path bubbles).
    - mreq & !mem_ready still freezes, and the flush count is held.
- Forwarding registers (update on clk):
  - Frozen: hold.
  - bubble_id_ex or flush_id_ex: load 00.
  - Otherwise fwd_a = 01 if ex_regwrite & !ex_memread & match(ex_ra3,id_ra1); else 10 if mem_regwrite & match(mem_ra3,id_ra1); else 00. fwd_b is the same using id_ra2.
  - 01 has priority over 10.
  - After a load-use bubble, the load is forwarded from WB (10).
- freeze=1 forces stall_pc, stall_if_id, bubble_id_ex and both flush outputs to 0.
- Counters:
  - stall_cnt increments every cycle stall_pc=1 or freeze=1.
  - flush_cnt increments once per accepted taken branch.
  - Both saturate at 2^CNT_W-1.
- err_timeout is cleared only by rst.
- rst mid-MEM_WAIT or mid-FLUSH: next cycle is RUN with all outputs 0.

Test Plan:
- Load-use: ex_memread=1, ex_regwrite=1, ex_ra3=5, id_ra1=5, id_use1=1 -> stall_pc/stall_if_id/bubble_id_ex=1 for exactly 1 cycle; stall_cnt=1; consumer later sees fwd_a=10.
- ALU forward: ex_regwrite=1, ex_ra3=3, id_ra2=3, and mem_ra3=3 with mem_regwrite=1 -> fwd_b=01 next cycle (EX beats MEM). With ex_ra3=0 -> fwd_b=10.
- Memory wait: mem_memread=1, mem_ready=0 for 3 cycles then 1 -> freeze=1 for 3 cycles, 0 on the 4th; fwd registers held; stall_cnt=3.
- Timeout: mem_ready held 0 -> freeze drops after 8 cycles; err_timeout=1 until rst.
- Branch with load-use: ex_branch_taken=1 together with lu -> flush_if_id=flush_id_ex=1, no stall; flush_if_id=1 on the next cycle (FLUSH_DEPTH=2); a second ex_branch_taken during FLUSH is ignored; flush_cnt=1.
- Saturation and reset: CNT_W=4, 20 stall cycles -> stall_cnt=15; rst asserted during MEM_WAIT -> next cycle all outputs 0.
